// File: rtl/usb_fifo_pkg.sv
// Shared constants and helpers for the USB endpoint FIFO.
package usb_fifo_pkg;

   localparam int unsigned DEFAULT_ADDR_WIDTH = 4;
   localparam int unsigned DEFAULT_DATA_WIDTH = 8;
   localparam int unsigned DEFAULT_DEPTH      = 2 ** DEFAULT_ADDR_WIDTH;

   // Ceiling log2, usable in constant expressions (clog2(1) == 0).
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself has no reset; only the output register does.
module fifo_ram
   import usb_fifo_pkg::*;
#(
   parameter int unsigned data_width = DEFAULT_DATA_WIDTH,
   parameter int unsigned depth      = DEFAULT_DEPTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       we,
   input  logic [clog2(depth)-1:0]    waddr,
   input  logic [data_width-1:0]      wdata,
   input  logic                       re,
   input  logic [clog2(depth)-1:0]    raddr,
   output logic [data_width-1:0]      q
);

   logic [data_width-1:0] mem [depth];

   // Write port.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Registered read port; holds its value when not reading.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= '0;
      else if (re) q <= mem[raddr];
   end

endmodule

// File: rtl/usb_ep_fifo.sv
// USB endpoint FIFO with packet-level commit/abort on the write side and
// commit/retry (rewind) on the read side.
module usb_ep_fifo
   import usb_fifo_pkg::*;
#(
   parameter int unsigned addr_width  = DEFAULT_ADDR_WIDTH,
   parameter int unsigned data_width  = DEFAULT_DATA_WIDTH,
   parameter int unsigned afull_level = 2 ** addr_width - 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [data_width-1:0] data,
   input  logic                  wrreq,
   input  logic                  wr_commit,
   input  logic                  wr_abort,
   input  logic                  rdreq,
   input  logic                  rd_commit,
   input  logic                  rd_retry,
   input  logic                  sclr,
   output logic [data_width-1:0] q,
   output logic [addr_width:0]   usedw,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_full,
   output logic                  overflow,
   output logic                  underflow
);

   typedef logic [addr_width:0] ptr_t;

   localparam ptr_t DEPTH_P = ptr_t'(2 ** addr_width);
   localparam ptr_t AFULL_P = ptr_t'(afull_level);

   ptr_t wr_ptr, wr_cmt, rd_ptr, rd_cmt;
   ptr_t occ, wr_ptr_nxt, rd_ptr_nxt;
   logic wr_en, rd_en;

   // Flags and counts derived from the registered pointers; accepted
   // transfers exclude same-cycle abort/retry/flush so the RAM never sees them.
   always_comb begin
      usedw       = wr_cmt - rd_ptr;
      empty       = (usedw == '0);
      occ         = wr_ptr - rd_cmt;
      full        = (occ == DEPTH_P);
      almost_full = (occ >= AFULL_P);
      wr_en       = wrreq && !full && !wr_abort && !sclr;
      rd_en       = rdreq && !empty && !rd_retry && !sclr;
      wr_ptr_nxt  = wr_ptr + ptr_t'(wr_en);
      rd_ptr_nxt  = rd_ptr + ptr_t'(rd_en);
   end

   // Pointer and status-pulse registers; flush beats everything, abort beats
   // commit, retry beats commit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         wr_cmt    <= '0;
         rd_ptr    <= '0;
         rd_cmt    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (sclr) begin
         wr_ptr    <= '0;
         wr_cmt    <= '0;
         rd_ptr    <= '0;
         rd_cmt    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= wrreq && full;
         underflow <= rdreq && empty;
         if (wr_abort) begin
            wr_ptr <= wr_cmt;
         end else begin
            wr_ptr <= wr_ptr_nxt;
            if (wr_commit) wr_cmt <= wr_ptr_nxt;
         end
         if (rd_retry) begin
            rd_ptr <= rd_cmt;
         end else begin
            rd_ptr <= rd_ptr_nxt;
            if (rd_commit) rd_cmt <= rd_ptr_nxt;
         end
      end
   end

   fifo_ram #(
      .data_width(data_width),
      .depth     (2 ** addr_width)
   ) u_ram (
      .clk  (clk),
      .reset(reset),
      .we   (wr_en),
      .waddr(wr_ptr[addr_width-1:0]),
      .wdata(data),
      .re   (rd_en),
      .raddr(rd_ptr[addr_width-1:0]),
      .q    (q)
   );

endmodule

// File: tb/tb_usb_ep_fifo.sv
// Directed self-checking bench for usb_ep_fifo (addr_width = 4, data_width = 8).
module tb_usb_ep_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data;
   logic       wrreq, wr_commit, wr_abort;
   logic       rdreq, rd_commit, rd_retry, sclr;
   logic [7:0] q;
   logic [4:0] usedw;
   logic       empty, full, almost_full, overflow, underflow;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [7:0] stream[40];

   usb_ep_fifo #(
      .addr_width (4),
      .data_width (8),
      .afull_level(15)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data       (data),
      .wrreq      (wrreq),
      .wr_commit  (wr_commit),
      .wr_abort   (wr_abort),
      .rdreq      (rdreq),
      .rd_commit  (rd_commit),
      .rd_retry   (rd_retry),
      .sclr       (sclr),
      .q          (q),
      .usedw      (usedw),
      .empty      (empty),
      .full       (full),
      .almost_full(almost_full),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wrreq = 0; wr_commit = 0; wr_abort = 0;
      rdreq = 0; rd_commit = 0; rd_retry = 0; sclr = 0;
   endtask

   task automatic wr(input logic [7:0] d, input logic c);
      data = d; wrreq = 1; wr_commit = c;
      tick();
      idle();
   endtask

   // Read one word; expected value goes through the scoreboard queue.
   task automatic rd(input logic [7:0] e, input logic c);
      rdreq = 1; rd_commit = c;
      exp_q.push_back(e);
      tick();
      idle();
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: observed empty queue expected entry");
      end else begin
         chk("q", q, exp_q.pop_front());
      end
   endtask

   initial begin
      idle();
      data  = 8'h00;
      reset = 1;
      tick();
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_afull", almost_full, 0);
      chk("rst_usedw", usedw, 0);
      chk("rst_q", q, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_udf", underflow, 0);
      reset = 0;
      tick();

      // Uncommitted writes are invisible to the reader
      wr(8'h11, 0); wr(8'h22, 0); wr(8'h33, 0);
      chk("uncmt_empty", empty, 1);
      chk("uncmt_usedw", usedw, 0);
      wr_commit = 1; tick(); idle();
      chk("cmt_usedw", usedw, 3);
      chk("cmt_empty", empty, 0);
      rd(8'h11, 1); rd(8'h22, 1); rd(8'h33, 1);
      chk("drain_empty", empty, 1);

      // Commit / abort / commit
      wr(8'hA0, 0); wr(8'hA1, 1);
      wr(8'hB0, 0); wr(8'hB1, 0);
      wr_abort = 1; tick(); idle();
      chk("abort_usedw", usedw, 2);
      wr(8'hC0, 1);
      chk("abort2_usedw", usedw, 3);
      rd(8'hA0, 1); rd(8'hA1, 1); rd(8'hC0, 1);

      // Read retry
      wr(8'd1, 0); wr(8'd2, 0); wr(8'd3, 0); wr(8'd4, 1);
      for (int i = 1; i <= 4; i++) rd(8'(i), 0);
      chk("pre_retry_usedw", usedw, 0);
      rd_retry = 1; tick(); idle();
      chk("retry_usedw", usedw, 4);
      for (int i = 1; i <= 4; i++) rd(8'(i), 0);
      rd_commit = 1; tick(); idle();
      chk("rcmt_full", full, 0);
      chk("rcmt_afull", almost_full, 0);
      chk("rcmt_empty", empty, 1);

      // Fill to full, overflow, uncommitted reads keep space occupied
      for (int i = 0; i < 16; i++) begin
         wr(8'h40 + 8'(i), (i == 15));
         if (i == 13) chk("af_at14", almost_full, 0);
         if (i == 14) begin
            chk("af_at15", almost_full, 1);
            chk("full_at15", full, 0);
         end
      end
      chk("full_at16", full, 1);
      chk("af_at16", almost_full, 1);
      chk("usedw_16", usedw, 16);
      wr(8'hEE, 1);
      chk("ovf_pulse", overflow, 1);
      chk("ovf_usedw", usedw, 16);
      tick();
      chk("ovf_clear", overflow, 0);
      for (int i = 0; i < 16; i++) rd(8'h40 + 8'(i), 0);
      chk("full_pending", full, 1);
      chk("empty_pending", empty, 1);
      rd_commit = 1; tick(); idle();
      chk("full_released", full, 0);

      // Continuous stream with per-cycle commits on both sides
      for (int i = 0; i < 40; i++) stream[i] = 8'((i * 7 + 3) & 8'hFF);
      wr(stream[0], 1);
      for (int i = 1; i < 40; i++) begin
         data = stream[i]; wrreq = 1; wr_commit = 1;
         rdreq = 1; rd_commit = 1;
         exp_q.push_back(stream[i-1]);
         tick();
         idle();
         chk("stream_q", q, exp_q.pop_front());
         chk("stream_ovf", overflow, 0);
         chk("stream_udf", underflow, 0);
      end
      rd(stream[39], 1);

      // Underflow on empty, q holds
      rdreq = 1; tick(); idle();
      chk("udf_pulse", underflow, 1);
      chk("udf_q_hold", q, stream[39]);
      tick();
      chk("udf_clear", underflow, 0);

      // wrreq + commit + abort in one cycle discards the word
      data = 8'h5A; wrreq = 1; wr_commit = 1; wr_abort = 1;
      tick(); idle();
      chk("wca_usedw", usedw, 0);
      chk("wca_empty", empty, 1);
      wr(8'h5B, 1);
      rd(8'h5B, 1);

      // Flush with pending data
      wr(8'h61, 0); wr(8'h62, 0); wr(8'h63, 1);
      chk("pre_sclr_usedw", usedw, 3);
      sclr = 1; rdreq = 1; tick(); idle();
      chk("sclr_empty", empty, 1);
      chk("sclr_usedw", usedw, 0);
      chk("sclr_q_hold", q, 8'h5B);
      chk("sclr_udf", underflow, 0);

      // Asynchronous reset between edges
      wr(8'h71, 0); wr(8'h72, 1);
      #2;
      reset = 1;
      #1;
      chk("arst_usedw", usedw, 0);
      chk("arst_empty", empty, 1);
      chk("arst_q", q, 0);
      chk("arst_full", full, 0);
      tick();
      reset = 0;
      tick();
      chk("post_arst_empty", empty, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/usb_ep_fifo.md
Name: usb_ep_fifo

Overview:
Parametrised endpoint FIFO with packet-level commit and rewind on both sides.
- Writer side (OUT data from SIE): speculative writes are committed on a good CRC/handshake, or discarded on error.
- Reader side (IN data to host): speculative reads are released on ACK, or rewound for retransmission on timeout/NAK.
- Sits between the SIE endpoint logic and the io bus; its FIFO-side signals follow the endpoint FIFO signal set.

Parameters:
addr_width, 4, log2 of depth; depth = 2**addr_width words
data_width, 8, word width in bits
afull_level, 2**addr_width-1, almost_full asserts when writer occupancy >= afull_level

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-high reset
data  input  data_width  write data
wrreq  input  1  write request
wr_commit  input  1  commit all speculative writes (packet good)
wr_abort  input  1  discard uncommitted writes (packet bad)
rdreq  input  1  read request
rd_commit  input  1  release all speculative reads (ACK received)
rd_retry  input  1  rewind read pointer to last committed point (retransmit)
sclr  input  1  synchronous clear (flush)
q  output  data_width  read data, registered
usedw  output  addr_width+1  committed words available to reader
empty  output  1  no committed word available to reader
full  output  1  no free space for writer
almost_full  output  1  writer occupancy >= afull_level
overflow  output  1  one-cycle pulse: wrreq while full
underflow  output  1  one-cycle pulse: rdreq while empty

Behaviour:
- Pointers: wr_ptr, wr_cmt, rd_ptr, rd_cmt, each addr_width+1 bits, modulo 2**(addr_width+1). Memory is indexed by the low addr_width bits; wrap-around is implicit.
- Reader count: usedw = wr_cmt - rd_ptr; empty = (usedw == 0).
- Writer occupancy: occ = wr_ptr - rd_cmt; full = (occ == depth); almost_full = (occ >= afull_level).
- Flags and usedw are combinational from the registered pointers. They are valid the cycle after any pointer update.
- Reset (asynchronous, active-high): all pointers 0, q = 0, overflow = 0, underflow = 0. Hence empty = 1, full = 0, almost_full = 0 (when afull_level > 0), usedw = 0.
- sclr has the highest priority and acts synchronously:
  - all pointers go to 0;
  - any wrreq/rdreq/commit/abort/retry in that cycle is ignored;
  - q holds its value.
- Write, accepted when wrreq && !full:
  - mem[wr_ptr] <= data; wr_ptr += 1.
  - wrreq && full: no write; overflow pulses for 1 cycle.
- wr_commit: wr_cmt <= next value of wr_ptr. A word accepted in the same cycle is included.
- wr_abort: wr_ptr <= wr_cmt. A word requested in the same cycle is discarded. overflow still pulses if full.
- wr_abort && wr_commit in the same cycle: abort wins.
- Read, accepted when rdreq && !empty:
  - q <= mem[rd_ptr] at the next edge (latency 1); rd_ptr += 1.
  - rdreq && empty: q holds; underflow pulses for 1 cycle.
- rd_commit: rd_cmt <= next value of rd_ptr. A read in the same cycle is included; the freed space is visible to the writer next cycle.
- rd_retry: rd_ptr <= rd_cmt. A read in the same cycle is cancelled; q holds.
- rd_retry && rd_commit in the same cycle: retry wins.
- Simultaneous write and read: both proceed independently.
  - A word committed in cycle N is readable from cycle N+1; no same-cycle bypass.
  - The memory read and write address spaces never overlap, because full is bounded by rd_cmt.
- Uncommitted reads still occupy space. The writer cannot overwrite words pending retransmission.

Decomposition:
- Package usb_fifo_pkg holds:
  - function clog2;
  - the default depth constant;
  - typedef ptr_t (addr_width+1 bits), built by a parametrised macro/function per instance.
- Sub-module fifo_ram is natural: a simple dual-port RAM with one write port and one registered read port, data_width x 2**addr_width, no reset on the array.

Test Plan:
- Write 3 words (0x11, 0x22, 0x33) without commit -> empty = 1, usedw = 0. Then wr_commit -> next cycle usedw = 3, empty = 0.
- Write 0xA0, 0xA1, commit; write 0xB0, 0xB1, wr_abort; write 0xC0, commit; read 3 -> q = 0xA0, 0xA1, 0xC0 (each 1 cycle after rdreq).
- Commit 4 words 1..4; read 4 without rd_commit; rd_retry; read 4 -> q = 1, 2, 3, 4 again. Then rd_commit -> occupancy 0, full = 0.
- addr_width = 4: write and commit 16 words -> full = 1, almost_full = 1. A 17th wrreq -> overflow pulses 1 cycle, data unchanged. Read 16 without rd_commit -> full stays 1; rd_commit -> full = 0.
- Continuous stream of 40 words, write+commit and read+commit every cycle (crosses wrap twice) -> output sequence equals input sequence; no overflow/underflow.
- Corner cases:
  - rdreq on empty -> underflow pulse, q unchanged.
  - wrreq+wr_commit+wr_abort in one cycle -> word discarded.
  - sclr with pending data -> empty = 1, usedw = 0.
  - reset asserted mid-stream (async, between edges) -> outputs go to reset values immediately.
